// File: rtl/boot_ctrl_if.sv
// Byte-stream and RAM-load signals of the boot loader, grouped for port binding.
// The loader takes the slave view; whatever feeds UART bytes and watches the load takes the master view.
interface boot_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;
  logic        cpu_running;
  logic        load_err;
  logic        busy;

  modport master (
    output rx_valid, rx_data,
    input  ld_valid, ld_addr, ld_data, cpu_running, load_err, busy
  );

  modport slave (
    input  rx_valid, rx_data,
    output ld_valid, ld_addr, ld_data, cpu_running, load_err, busy
  );
endinterface

// File: rtl/boot_ctrl.sv
// UART boot loader: receives frames of A5, LEN (little endian), LEN payload bytes and an XOR
// checksum, writes the payload into RAM from address 0 and releases the CPU on a good checksum.
module boot_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_LEN        = 4096
) (
  input logic        clk,
  input logic        i_reset,
  boot_ctrl_if.slave bus
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state, state_next;
  logic [15:0] len_q, len_next;
  logic [7:0]  chk_q, chk_next;
  logic [15:0] idx_q, idx_next;
  logic [31:0] idle_q, idle_next;

  logic        ld_valid_q, ld_valid_next;
  logic [31:0] ld_addr_q, ld_addr_next;
  logic [7:0]  ld_data_q, ld_data_next;
  logic        cpu_running_q;
  logic        load_err_q;
  logic        busy_q, busy_next;

  logic        in_frame;
  logic [15:0] len_full;
  logic [31:0] idle_inc;

  assign in_frame = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  assign len_full = {bus.rx_data, len_q[7:0]};
  assign idle_inc = idle_q + 32'd1;

  // NOTE: every variable driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    len_next      = len_q;
    chk_next      = chk_q;
    idx_next      = idx_q;
    idle_next     = '0;
    ld_valid_next = 1'b0;
    ld_addr_next  = ld_addr_q;
    ld_data_next  = ld_data_q;

    if (bus.rx_valid) begin
      case (state)
        S_IDLE, S_ERR: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_next = S_LEN_LO;
            chk_next   = '0;
            idx_next   = '0;
          end
        end
        S_LEN_LO: begin
          len_next   = {len_q[15:8], bus.rx_data};
          state_next = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_next = len_full;
          if (32'(len_full) > MAX_LEN) begin
            state_next = S_ERR;
          end else if (len_full == 16'd0) begin
            state_next = S_CHK;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          ld_valid_next = 1'b1;
          ld_addr_next  = 32'(idx_q);
          ld_data_next  = bus.rx_data;
          chk_next      = chk_q ^ bus.rx_data;
          idx_next      = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1) begin
            state_next = S_CHK;
          end
        end
        S_CHK: begin
          state_next = (bus.rx_data == chk_q) ? S_RUN : S_ERR;
        end
        S_RUN: begin
          state_next = S_RUN;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end else if (in_frame) begin
      // A byte in the same cycle as the limit is reached takes priority over the timeout.
      idle_next = idle_inc;
      if (idle_inc == TIMEOUT_CYCLES) begin
        state_next = S_ERR;
        idle_next  = '0;
      end
    end

    busy_next = state_next inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      chk_q         <= '0;
      idx_q         <= '0;
      idle_q        <= '0;
      ld_valid_q    <= 1'b0;
      ld_addr_q     <= '0;
      ld_data_q     <= '0;
      cpu_running_q <= 1'b0;
      load_err_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_next;
      len_q         <= len_next;
      chk_q         <= chk_next;
      idx_q         <= idx_next;
      idle_q        <= idle_next;
      ld_valid_q    <= ld_valid_next;
      ld_addr_q     <= ld_addr_next;
      ld_data_q     <= ld_data_next;
      cpu_running_q <= (state_next == S_RUN);
      load_err_q    <= (state_next == S_ERR);
      busy_q        <= busy_next;
    end
  end

  assign bus.ld_valid    = ld_valid_q;
  assign bus.ld_addr     = ld_addr_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.cpu_running = cpu_running_q;
  assign bus.load_err    = load_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: frame-level reference model compared every cycle, directed frames with
// literal expectations, then randomized frames with junk, bad lengths, bad checksums and long gaps.
module tb_boot_ctrl;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned MAXLEN  = 16;

  logic clk = 1'b0;
  logic i_reset;

  boot_ctrl_if bus ();

  boot_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_LEN(MAXLEN)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the design at each rising edge.
  logic       s_rst, s_v;
  logic [7:0] s_d;
  always @(posedge clk) begin
    s_rst <= i_reset;
    s_v   <= bus.rx_valid;
    s_d   <= bus.rx_data;
  end

  // Reference model: the bytes of the current frame after the sync byte, kept as a queue.
  byte unsigned frame[$];
  bit          m_in_frame, m_running, m_err, m_ld_valid;
  logic [31:0] m_ld_addr = '0;
  logic [7:0]  m_ld_data = '0;
  int          m_idle, m_len;

  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  wr_t wlog[$];

  task automatic model_abort();
    m_in_frame = 1'b0;
    m_err      = 1'b1;
  endtask

  task automatic model_step();
    int n;
    byte unsigned x;
    m_ld_valid = 1'b0;
    if (s_rst === 1'b1) begin
      frame.delete();
      m_in_frame = 1'b0; m_running = 1'b0; m_err = 1'b0;
      m_ld_addr = '0; m_ld_data = '0; m_idle = 0; m_len = 0;
    end else if (m_running) begin
      m_running = 1'b1;
    end else if (!m_in_frame) begin
      if (s_v === 1'b1 && s_d == 8'hA5) begin
        m_in_frame = 1'b1; m_err = 1'b0; m_idle = 0;
        frame.delete();
      end
    end else if (s_v === 1'b1) begin
      m_idle = 0;
      frame.push_back(s_d);
      n = int'(frame.size());
      if (n == 2) begin
        m_len = int'(frame[0]) + 256 * int'(frame[1]);
        if (m_len > int'(MAXLEN)) model_abort();
      end else if (n >= 3 && n <= 2 + m_len) begin
        m_ld_valid = 1'b1;
        m_ld_addr  = 32'(n - 3);
        m_ld_data  = s_d;
      end else if (n == 3 + m_len) begin
        x = 8'h00;
        for (int i = 2; i < n - 1; i++) x ^= frame[i];
        if (x == s_d) begin
          m_running  = 1'b1;
          m_in_frame = 1'b0;
        end else begin
          model_abort();
        end
      end
    end else begin
      m_idle++;
      if (m_idle == int'(TIMEOUT)) model_abort();
    end
  endtask

  always @(negedge clk) begin
    model_step();
    if (cmp_en) begin
      check("ld_valid",    32'(bus.ld_valid),    32'(m_ld_valid));
      check("ld_addr",     bus.ld_addr,          m_ld_addr);
      check("ld_data",     32'(bus.ld_data),     32'(m_ld_data));
      check("cpu_running", 32'(bus.cpu_running), 32'(m_running));
      check("load_err",    32'(bus.load_err),    32'(m_err));
      check("busy",        32'(bus.busy),        32'(m_in_frame));
    end
    if (bus.ld_valid === 1'b1) wlog.push_back('{bus.ld_addr, bus.ld_data});
  end

  // Stimulus helpers; all are entered and left on a falling edge.
  byte unsigned seq[$];

  task automatic send_byte(input byte unsigned b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i], 0);
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    bus.rx_valid = 1'($urandom_range(0, 1));
    bus.rx_data  = 8'($urandom);
    @(negedge clk);
    i_reset      = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 2));
    if (r < 18) return int'($urandom_range(3, 10));
    return int'($urandom_range(45, 55));
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ld_valid"},    32'(bus.ld_valid),    32'h0);
    check({tag, "_ld_addr"},     bus.ld_addr,          32'h0);
    check({tag, "_ld_data"},     32'(bus.ld_data),     32'h0);
    check({tag, "_cpu_running"}, 32'(bus.cpu_running), 32'h0);
    check({tag, "_load_err"},    32'(bus.load_err),    32'h0);
    check({tag, "_busy"},        32'(bus.busy),        32'h0);
  endtask

  logic [31:0] exp_addr[3] = '{32'h0, 32'h1, 32'h2};
  logic [7:0]  exp_data[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int          len, npay, gap;
    byte unsigned b, x;
    i_reset      = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    cmp_en  = 1'b1;
    check_reset_values("reset");

    // Good three-byte frame.
    wlog.delete();
    seq = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    send_seq();
    check("run_before_chk", 32'(bus.cpu_running), 32'h0);
    send_byte(8'h00, 0);
    check("run_after_chk", 32'(bus.cpu_running), 32'h1);
    check("err_after_good", 32'(bus.load_err), 32'h0);
    @(negedge clk);
    check("good_nwrites", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("good_addr", (i < wlog.size()) ? wlog[i].addr : 32'hFFFF_FFFF, exp_addr[i]);
      check("good_data", (i < wlog.size()) ? 32'(wlog[i].data) : 32'hFFFF_FFFF, 32'(exp_data[i]));
    end

    // Bad checksum, then recovery from the error state.
    do_reset();
    wlog.delete();
    seq = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    send_seq();
    check("badchk_err", 32'(bus.load_err), 32'h1);
    check("badchk_run", 32'(bus.cpu_running), 32'h0);
    check("badchk_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("badchk_nwrites", 32'(wlog.size()), 32'd2);
    send_byte(8'hA5, 0);
    check("resync_err_clear", 32'(bus.load_err), 32'h0);
    check("resync_busy", 32'(bus.busy), 32'h1);
    seq = '{8'h01, 8'h00, 8'h7E, 8'h7E};
    send_seq();
    check("recover_run", 32'(bus.cpu_running), 32'h1);

    // Leading junk, zero-length frame.
    do_reset();
    wlog.delete();
    seq = '{8'h12, 8'h34};
    send_seq();
    check("junk_busy", 32'(bus.busy), 32'h0);
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    check("zero_len_run", 32'(bus.cpu_running), 32'h1);
    @(negedge clk);
    check("zero_len_nwrites", 32'(wlog.size()), 32'd0);

    // Timeout after exactly TIMEOUT idle cycles.
    do_reset();
    seq = '{8'hA5, 8'h04, 8'h00, 8'h01};
    send_seq();
    repeat (TIMEOUT - 1) @(negedge clk);
    check("pre_timeout_busy", 32'(bus.busy), 32'h1);
    check("pre_timeout_err", 32'(bus.load_err), 32'h0);
    @(negedge clk);
    check("timeout_err", 32'(bus.load_err), 32'h1);
    check("timeout_busy", 32'(bus.busy), 32'h0);
    // Byte after 48 idle cycles, then one arriving on the limit cycle itself.
    seq = '{8'hA5, 8'h04, 8'h00};
    send_seq();
    send_byte(8'h01, int'(TIMEOUT) - 2);
    send_byte(8'h02, int'(TIMEOUT) - 1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h04, 0);
    check("late_bytes_run", 32'(bus.cpu_running), 32'h1);
    check("late_bytes_err", 32'(bus.load_err), 32'h0);

    // Length above MAX_LEN.
    do_reset();
    wlog.delete();
    seq = '{8'hA5, 8'h11, 8'h00};
    send_seq();
    check("overlen_err", 32'(bus.load_err), 32'h1);
    check("overlen_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("overlen_nwrites", 32'(wlog.size()), 32'd0);

    // Reset mid-payload, then a clean frame loads from address 0, then reset from RUN.
    do_reset();
    seq = '{8'hA5, 8'h04, 8'h00, 8'hAA, 8'hBB};
    send_seq();
    i_reset      = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hCC;
    @(negedge clk);
    i_reset      = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_values("midreset");
    @(negedge clk);
    check("midreset_no_write", 32'(bus.ld_valid), 32'h0);
    wlog.delete();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h5A, 8'h3C, 8'h66};
    send_seq();
    check("after_reset_run", 32'(bus.cpu_running), 32'h1);
    @(negedge clk);
    check("after_reset_nwrites", 32'(wlog.size()), 32'd2);
    check("after_reset_addr0", (wlog.size() > 0) ? wlog[0].addr : 32'hFFFF_FFFF, 32'h0);
    check("after_reset_data0", (wlog.size() > 0) ? 32'(wlog[0].data) : 32'hFFFF_FFFF, 32'h5A);
    do_reset();
    check_reset_values("runreset");

    // Randomized frames.
    for (int f = 0; f < 150; f++) begin
      if (m_running || $urandom_range(0, 3) == 0) do_reset();
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom), pick_gap());
      send_byte(8'hA5, pick_gap());
      len = int'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) len = len + 256 * int'($urandom_range(1, 255));
      send_byte(8'(len), pick_gap());
      send_byte(8'(len >> 8), pick_gap());
      npay = (len > int'(MAXLEN)) ? int'($urandom_range(0, 3)) : len;
      x = 8'h00;
      for (int i = 0; i < npay; i++) begin
        b = 8'($urandom);
        x ^= b;
        send_byte(b, pick_gap());
        if ($urandom_range(0, 60) == 0) do_reset();
      end
      gap = pick_gap();
      send_byte(($urandom_range(0, 4) == 0) ? 8'($urandom) : x, gap);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000; max idle cycles between bytes inside a frame.
REQ-002 Parameter MAX_LEN, default 4096; largest accepted payload length in bytes.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk in, i_reset in.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data holds a received UART byte.
REQ-007 rx_data  input  8  received byte, valid only when rx_valid=1.
REQ-008 ld_valid  output  1  one-cycle RAM byte-write strobe.
REQ-009 ld_addr  output  32  RAM byte address for ld_data.
REQ-010 ld_data  output  8  byte to write into RAM.
REQ-011 cpu_running  output  1  CPU release; 0 = held, RAM owned by loader.
REQ-012 load_err  output  1  sticky error flag for the last frame.
REQ-013 busy  output  1  high while a frame is being received (states LEN_LO..CHK).

Function
REQ-014 Frame format SHALL be: sync 0xA5, LEN low byte, LEN high byte, LEN payload bytes, one checksum byte equal to XOR of all payload bytes.
REQ-015 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHK, RUN, ERR; state advances only on rx_valid except timeout.
REQ-016 IDLE: rx_data=0xA5 -> LEN_LO; any other byte ignored, stay IDLE.
REQ-017 LEN_LO captures LEN[7:0] -> LEN_HI; LEN_HI captures LEN[15:8].
REQ-018 From LEN_HI: LEN>MAX_LEN -> ERR; LEN=0 -> CHK (expected checksum 0x00); else -> DATA.
REQ-019 DATA: each byte SHALL produce ld_valid=1 exactly one cycle after the rx_valid cycle, with ld_data=byte, ld_addr=payload index zero-extended (first byte 0x00000000).
REQ-020 Running checksum SHALL be XOR of payload bytes, cleared on entry to LEN_LO; after byte LEN-1 -> CHK.
REQ-021 CHK: byte equals checksum -> RUN; mismatch -> ERR.
REQ-022 RUN: cpu_running=1 registered, asserted the cycle after the checksum byte's rx_valid; all rx bytes ignored; RUN left only by i_reset.
REQ-023 ERR: load_err=1, cpu_running=0; rx_data=0xA5 -> LEN_LO with load_err cleared that cycle; other bytes ignored.
REQ-024 Timeout: 32-bit idle counter in LEN_LO, LEN_HI, DATA, CHK, cleared on each rx_valid and on state entry; reaching TIMEOUT_CYCLES -> ERR.
REQ-025 rx_valid in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: byte processed, no timeout.
REQ-026 ld_valid SHALL be 0 in every state except the cycle after a DATA byte; ld_addr/ld_data hold last values otherwise.
REQ-027 A new 0xA5 arriving mid-frame SHALL be treated as data/length, not resync.
REQ-028 ld_addr SHALL never exceed MAX_LEN-1; addr counter width 16 bits internally, wrap impossible given REQ-018.

Reset
REQ-029 On i_reset=1 at a clock edge: state=IDLE, cpu_running=0, ld_valid=0, ld_addr=0, ld_data=0, load_err=0, busy=0, checksum=0, LEN=0, idle counter=0.
REQ-030 Reset mid-frame or in RUN SHALL abandon the frame and re-hold the CPU the next cycle; no ld_valid issued during or the cycle after reset.

Verification
REQ-031 Send A5 03 00 11 22 33 00 -> ld_valid x3 with (0,11),(1,22),(2,33); cpu_running=1 one cycle after last byte; load_err=0.
REQ-032 Send A5 02 00 AA 55 00 (expected FF) -> two writes, state ERR, load_err=1, cpu_running=0; then A5 01 00 7E 7E -> load_err=0, cpu_running=1.
REQ-033 Send 12 34 A5 00 00 00 -> leading bytes ignored, no ld_valid, cpu_running=1.
REQ-034 TIMEOUT_CYCLES=50: send A5 04 00 01 then silence 50 cycles -> load_err=1, busy=0; byte at cycle 49 after last instead -> no error.
REQ-035 MAX_LEN=16: send A5 11 00 -> ERR immediately, no ld_valid.
REQ-036 Assert i_reset during DATA after 2 of 4 bytes, and again while in RUN -> all outputs return to reset values next edge; following complete frame loads from address 0.
